// File: rtl/draw_sequencer.sv
// draw_sequencer: drives a VGA-style pixel writer through an optional full
// screen clear sweep (160x120) followed by a BOX_W x BOX_H filled box, then
// pulses done for one cycle.
//
// Build option: define CLEAR_PHASE_EN to include the clear sweep (CLEAR state
// and its raster counters). When the macro is left undefined, the sequencer
// goes from IDLE straight to BOX.
module draw_sequencer #(
  parameter int unsigned BOX_W        = 4,
  parameter int unsigned BOX_H        = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] box_x,
  input  logic [6:0] box_y,
  input  logic [2:0] box_colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BOX   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Screen geometry and box extents. Counters are 5 bits so a 16-pixel box
  // edge (offset 15) fits with headroom.
  localparam logic [7:0] SCR_X_LAST = 8'd159;
  localparam logic [6:0] SCR_Y_LAST = 7'd119;
  localparam logic [8:0] SCR_W      = 9'd160;
  localparam logic [7:0] SCR_H      = 8'd120;
  localparam logic [4:0] DX_LAST    = 5'(BOX_W - 1);
  localparam logic [4:0] DY_LAST    = 5'(BOX_H - 1);

  state_t     state_q, state_d;

  // Box parameters captured when a frame is accepted; frozen for the frame.
  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic [2:0] bc_q, bc_d;

  // Offset of the box pixel currently on the outputs.
  logic [4:0] dx_q, dx_d;
  logic [4:0] dy_q, dy_d;

  // Registered pixel outputs.
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;

  // Next box pixel position, widened so off-screen pixels never wrap back
  // onto the visible area.
  logic       emit_box;
  logic [8:0] px;
  logic [7:0] py;

`ifdef CLEAR_PHASE_EN
  // Raster position of the clear pixel currently on the outputs.
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
`endif

  // Next-state and next-output logic; outputs are registered from the _d values
  // so each pixel appears in the cycle following the edge that selects it.
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    bc_d     = bc_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    emit_box = 1'b0;
    px       = '0;
    py       = '0;
`ifdef CLEAR_PHASE_EN
    cx_d     = cx_q;
    cy_d     = cy_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          bx_d = box_x;
          by_d = box_y;
          bc_d = box_colour;
          dx_d = '0;
          dy_d = '0;
`ifdef CLEAR_PHASE_EN
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
          x_d     = '0;
          y_d     = '0;
          col_d   = CLEAR_COLOUR;
          plot_d  = 1'b1;
`else
          state_d  = BOX;
          emit_box = 1'b1;
`endif
        end
      end

`ifdef CLEAR_PHASE_EN
      CLEAR: begin
        if (cx_q == SCR_X_LAST) begin
          cx_d = '0;
          if (cy_q == SCR_Y_LAST) begin
            cy_d     = '0;
            dx_d     = '0;
            dy_d     = '0;
            state_d  = BOX;
            emit_box = 1'b1;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
        if (state_d == CLEAR) begin
          x_d    = cx_d;
          y_d    = cy_d;
          col_d  = CLEAR_COLOUR;
          plot_d = 1'b1;
        end
      end
`endif

      BOX: begin
        if (dx_q == DX_LAST) begin
          dx_d = '0;
          if (dy_q == DY_LAST) begin
            dy_d    = '0;
            state_d = DONE;
          end else begin
            dy_d     = dy_q + 5'd1;
            emit_box = 1'b1;
          end
        end else begin
          dx_d     = dx_q + 5'd1;
          emit_box = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Box pixels off the visible screen still take their cycle but do not plot.
    if (emit_box) begin
      px     = {1'b0, bx_d} + 9'(dx_d);
      py     = {1'b0, by_d} + 8'(dy_d);
      x_d    = px[7:0];
      y_d    = py[6:0];
      col_d  = bc_d;
      plot_d = (px < SCR_W) && (py < SCR_H);
    end
  end

  // State, latches, counters and output registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      bc_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
`ifdef CLEAR_PHASE_EN
      cx_q    <= '0;
      cy_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bc_q    <= bc_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
`ifdef CLEAR_PHASE_EN
      cx_q    <= cx_d;
      cy_q    <= cy_d;
`endif
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign plot       = plot_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
